instr_fetch: RTL and testbench



---
 rtl/instr_fetch.sv | 170 +++++++++++++++++
 tb/tb_instr_fetch.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit: assembles 32-bit words from a byte-wide program memory
// (MSB first) into a small prefetch FIFO consumed by the decoder over valid/ready.
//
// state | meaning
// IDLE  | no request outstanding, waiting for FIFO space
// FETCH | mem_req high, collecting byte idx_q of the word at ptr_q
// DRAIN | redirect arrived with a request pending; swallow the stale response
module instr_fetch #(
    parameter int unsigned ADDR_SIZE  = 16,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned RESET_ADDR = 0
) (
    input  logic                 clk,
    input  logic                 rstn,
    output logic                 mem_req,
    output logic [ADDR_SIZE+1:0] mem_addr,
    input  logic [7:0]           mem_data,
    input  logic                 mem_valid,
    output logic [31:0]          instr,
    output logic [ADDR_SIZE-1:0] instr_addr,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    input  logic                 redirect,
    input  logic [ADDR_SIZE-1:0] redirect_addr
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
    localparam logic [ADDR_SIZE-1:0] RST_PTR = ADDR_SIZE'(RESET_ADDR);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t                 state_q, state_d;
    logic                   mem_req_q, mem_req_d;
    logic [ADDR_SIZE+1:0]   mem_addr_q, mem_addr_d;
    logic [1:0]             idx_q, idx_d;
    logic [ADDR_SIZE-1:0]   ptr_q, ptr_d;
    logic [23:0]            part_q, part_d;
    logic [PW-1:0]          rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]          cnt_q, cnt_d, cnt_after;
    logic [31:0]            last_instr_q, last_instr_d;
    logic [ADDR_SIZE-1:0]   last_addr_q, last_addr_d;
    logic [31:0]            fifo_instr_q [DEPTH];
    logic [ADDR_SIZE-1:0]   fifo_addr_q  [DEPTH];
    logic                   push, pop, accept;

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign instr_valid = (cnt_q != '0);
    // Outputs hold the last presented head once the FIFO empties or is flushed
    assign instr       = instr_valid ? fifo_instr_q[rd_q] : last_instr_q;
    assign instr_addr  = instr_valid ? fifo_addr_q[rd_q]  : last_addr_q;
    assign accept      = mem_req_q & mem_valid;

    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        idx_d        = idx_q;
        ptr_d        = ptr_q;
        part_d       = part_q;
        last_instr_d = instr;
        last_addr_d  = instr_addr;
        push         = 1'b0;
        pop          = instr_valid & instr_ready;
        cnt_after    = cnt_q + CW'(1) - CW'(pop);

        case (state_q)
            IDLE: begin
                if (cnt_q < CNT_MAX) begin
                    state_d    = FETCH;
                    mem_req_d  = 1'b1;
                    idx_d      = 2'd0;
                    mem_addr_d = {ptr_q, 2'b00};
                end
            end
            FETCH: begin
                if (accept) begin
                    case (idx_q)
                        2'd0:    part_d[23:16] = mem_data;
                        2'd1:    part_d[15:8]  = mem_data;
                        2'd2:    part_d[7:0]   = mem_data;
                        default: push          = 1'b1;
                    endcase
                    if (idx_q == 2'd3) begin
                        ptr_d      = ptr_q + ADDR_SIZE'(1);
                        idx_d      = 2'd0;
                        mem_addr_d = {ptr_d, 2'b00};
                        if (cnt_after >= CNT_MAX) begin
                            state_d   = IDLE;
                            mem_req_d = 1'b0;
                        end
                    end else begin
                        idx_d      = idx_q + 2'd1;
                        mem_addr_d = {ptr_q, idx_d};
                    end
                end
            end
            DRAIN: begin
                if (mem_valid) begin
                    state_d    = FETCH;
                    idx_d      = 2'd0;
                    mem_addr_d = {ptr_q, 2'b00};
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        wr_d  = push ? wr_q + PW'(1) : wr_q;
        rd_d  = pop  ? rd_q + PW'(1) : rd_q;
        cnt_d = cnt_q + CW'(push) - CW'(pop);

        if (redirect) begin
            push   = 1'b0;
            rd_d   = '0;
            wr_d   = '0;
            cnt_d  = '0;
            ptr_d  = redirect_addr;
            part_d = '0;
            idx_d  = 2'd0;
            if (mem_req_q && !mem_valid) begin
                state_d    = DRAIN;
                mem_req_d  = 1'b1;
                mem_addr_d = mem_addr_q;
            end else begin
                state_d    = FETCH;
                mem_req_d  = 1'b1;
                mem_addr_d = {redirect_addr, 2'b00};
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= {RST_PTR, 2'b00};
            idx_q        <= 2'd0;
            ptr_q        <= RST_PTR;
            part_q       <= '0;
            rd_q         <= '0;
            wr_q         <= '0;
            cnt_q        <= '0;
            last_instr_q <= '0;
            last_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            idx_q        <= idx_d;
            ptr_q        <= ptr_d;
            part_q       <= part_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            cnt_q        <= cnt_d;
            last_instr_q <= last_instr_d;
            last_addr_q  <= last_addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr_q[wr_q] <= {part_q, mem_data};
            fifo_addr_q[wr_q]  <= ptr_q;
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch: a byte memory responder plus an in-order
// instruction-stream scoreboard, with directed latency/flush/wrap/reset scenarios.
module tb_instr_fetch;
    logic        clk;
    logic        rstn;
    logic        mem_req;
    logic [17:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_valid;
    logic [31:0] instr;
    logic [15:0] instr_addr;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [15:0] redirect_addr;

    int          checks = 0;
    int          errors = 0;
    int          wait_pct = 0;
    logic        force_stall = 1'b0;
    logic [15:0] exp_addr = 16'd0;
    logic [7:0]  mem [0:262143];

    instr_fetch #(.ADDR_SIZE(16), .DEPTH(4), .RESET_ADDR(0)) dut (
        .clk(clk), .rstn(rstn), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_valid(mem_valid), .instr(instr),
        .instr_addr(instr_addr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .redirect(redirect),
        .redirect_addr(redirect_addr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [15:0] a);
        logic [17:0] b;
        b = {a, 2'b00};
        return {mem[b], mem[b | 18'd1], mem[b | 18'd2], mem[b | 18'd3]};
    endfunction

    // Called at a falling edge: drive the memory response, score any pop, advance one clock.
    task automatic cyc();
        if (mem_req && !force_stall && ($urandom_range(99) >= wait_pct)) begin
            mem_valid = 1'b1;
            mem_data  = mem[mem_addr];
        end else begin
            mem_valid = 1'b0;
            mem_data  = 8'($urandom);
        end
        if (rstn && instr_valid && instr_ready && !redirect) begin
            check("pop_addr", 64'(instr_addr), 64'(exp_addr));
            check("pop_data", 64'(instr), 64'(exp_word(exp_addr)));
            exp_addr = exp_addr + 16'd1;
        end
        if (redirect) exp_addr = redirect_addr;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_valid(input int limit, output int n);
        n = 0;
        while (!instr_valid && n < limit) begin
            cyc();
            n++;
        end
    endtask

    int n;
    int np;

    initial begin
        for (int i = 0; i < 262144; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56; mem[3] = 8'h78;

        rstn = 1'b0; instr_ready = 1'b1; redirect = 1'b0; redirect_addr = 16'd0;
        mem_valid = 1'b0; mem_data = 8'd0;
        repeat (2) @(negedge clk);
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_valid", 64'(instr_valid), 64'd0);
        check("rst_instr", 64'(instr), 64'd0);
        check("rst_instr_addr", 64'(instr_addr), 64'd0);

        // zero-wait start-up latency and steady-state rate
        rstn = 1'b1; exp_addr = 16'd0;
        cyc();
        check("first_req", 64'(mem_req), 64'd1);
        check("first_addr", 64'(mem_addr), 64'd0);
        wait_valid(8, n);
        check("first_lat", 64'(n), 64'd4);
        check("first_instr", 64'(instr), 64'h12345678);
        check("first_iaddr", 64'(instr_addr), 64'd0);
        cyc();
        wait_valid(8, n);
        check("steady_lat", 64'(n + 1), 64'd4);
        check("second_iaddr", 64'(instr_addr), 64'd1);

        // backpressure: FIFO fills to depth then fetching stops
        instr_ready = 1'b0; redirect = 1'b1; redirect_addr = 16'd0;
        cyc();
        redirect = 1'b0;
        repeat (24) cyc();
        check("full_req_low", 64'(mem_req), 64'd0);
        check("full_valid", 64'(instr_valid), 64'd1);
        check("full_head", 64'(instr_addr), 64'd0);
        instr_ready = 1'b1;
        cyc();
        instr_ready = 1'b0;
        n = 0;
        while (!mem_req && n < 6) begin cyc(); n++; end
        check("resume_addr", 64'(mem_addr), 64'h10);
        n = 0;
        while (mem_req && n < 30) begin cyc(); n++; end
        force_stall = 1'b1; instr_ready = 1'b1;
        np = 0;
        while (instr_valid && np < 10) begin cyc(); np++; end
        check("queued_words", 64'(np), 64'd4);

        // redirect with 3 words queued and byte 2 in flight
        force_stall = 1'b0; instr_ready = 1'b0;
        redirect = 1'b1; redirect_addr = 16'h0020;
        cyc();
        redirect = 1'b0;
        repeat (14) cyc();
        check("pre_redir_addr", 64'(mem_addr), 64'h8E);
        check("pre_redir_valid", 64'(instr_valid), 64'd1);
        check("pre_redir_head", 64'(instr_addr), 64'h20);
        redirect = 1'b1; redirect_addr = 16'h0040; instr_ready = 1'b1;
        cyc();
        redirect = 1'b0;
        check("flush_valid", 64'(instr_valid), 64'd0);
        check("redir_mem_addr", 64'(mem_addr), 64'h100);
        check("redir_mem_req", 64'(mem_req), 64'd1);
        wait_valid(10, n);
        check("redir_lat", 64'(n), 64'd4);
        check("redir_iaddr", 64'(instr_addr), 64'h40);

        // redirect while a request is stalled: stale response must be dropped
        force_stall = 1'b1;
        cyc();
        check("stall_addr", 64'(mem_addr), 64'h104);
        redirect = 1'b1; redirect_addr = 16'h0080;
        cyc();
        redirect = 1'b0;
        check("drain_req", 64'(mem_req), 64'd1);
        check("drain_addr", 64'(mem_addr), 64'h104);
        check("drain_valid", 64'(instr_valid), 64'd0);
        cyc(); cyc();
        check("drain_addr2", 64'(mem_addr), 64'h104);
        force_stall = 1'b0;
        cyc();
        check("post_drain_addr", 64'(mem_addr), 64'h200);
        wait_valid(10, n);
        check("drain_lat", 64'(n), 64'd4);
        check("drain_iaddr", 64'(instr_addr), 64'h80);

        // fetch pointer wrap-around
        redirect = 1'b1; redirect_addr = 16'hFFFF;
        cyc();
        redirect = 1'b0;
        wait_valid(10, n);
        check("wrap_top", 64'(instr_addr), 64'hFFFF);
        cyc();
        wait_valid(10, n);
        check("wrap_zero", 64'(instr_addr), 64'h0000);
        check("wrap_data", 64'(instr), 64'(exp_word(16'h0000)));

        // randomized traffic: wait states, backpressure, redirects
        wait_pct = 30;
        for (int i = 0; i < 3000; i++) begin
            instr_ready   = ((i / 200) % 3 == 2) ? 1'b0 : ($urandom_range(3) != 0);
            redirect      = ($urandom_range(49) == 0);
            redirect_addr = 16'($urandom);
            cyc();
        end
        redirect = 1'b0;

        // asynchronous reset during byte 2
        wait_pct = 0; instr_ready = 1'b1;
        redirect = 1'b1; redirect_addr = 16'h0010;
        cyc();
        redirect = 1'b0;
        cyc(); cyc();
        check("mid_byte2", 64'(mem_addr), 64'h42);
        rstn = 1'b0; mem_valid = 1'b0;
        #1;
        check("arst_mem_req", 64'(mem_req), 64'd0);
        check("arst_mem_addr", 64'(mem_addr), 64'd0);
        check("arst_valid", 64'(instr_valid), 64'd0);
        check("arst_instr", 64'(instr), 64'd0);
        check("arst_iaddr", 64'(instr_addr), 64'd0);
        @(negedge clk);
        rstn = 1'b1; exp_addr = 16'd0;
        wait_valid(10, n);
        check("arst_lat", 64'(n), 64'd5);
        check("arst_iaddr2", 64'(instr_addr), 64'd0);
        check("arst_instr2", 64'(instr), 64'h12345678);
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
